// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_ODD      = 2'b01;
    localparam logic [1:0] PAR_EVEN     = 2'b10;
    localparam logic [1:0] PAR_EVEN_ALT = 2'b11;

    localparam int MIN_DATA_BITS = 5;
    localparam int MAX_DATA_BITS = 9;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic brk;
    } rx_status_t;

    function automatic logic par_enabled(input logic [1:0] mode);
        return mode != PAR_NONE;
    endfunction

endpackage

// File: rtl/rx_bit_sampler.sv
// Input synchronizer and bit-value decision, one cycle after the sample point.
// RX_MAJORITY_VOTE_EN selects a 3-sample majority vote around the sample point.
module rx_bit_sampler #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rxs_o,
    output logic bit_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '1;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end

    assign rxs_o = sync_q[SYNC_STAGES-1];

`ifdef RX_MAJORITY_VOTE_EN
    // hist_q[0] is rxs at the sample point, hist_q[1] the cycle before it
    logic [1:0] hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) hist_q <= '1;
        else         hist_q <= {hist_q[0], rxs_o};
    end

    assign bit_o = (rxs_o & hist_q[0]) | (rxs_o & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    logic hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) hist_q <= 1'b1;
        else         hist_q <= rxs_o;
    end

    assign bit_o = hist_q;
`endif

endmodule

// File: rtl/rx_deframer.sv
// UART receive deframer: baud timing, frame FSM and held output word.
// Optional RX_MAJORITY_VOTE_EN enables majority voting in rx_bit_sampler.
module rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int CLK_DIV_W   = 16,
    parameter int SYNC_STAGES = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [CLK_DIV_W-1:0] cr_clk_div_i,
    input  logic [3:0]           cr_ds_i,
    input  logic [1:0]           cr_p_i,
    input  logic                 cr_s_i,
    input  logic                 uart_rx_i,
    output logic [DATA_W-1:0]    data_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 overrun_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam logic [3:0]           DW     = 4'(DATA_W);
    localparam logic [3:0]           MIN_DS = 4'(MIN_DATA_BITS);
    localparam logic [CLK_DIV_W-1:0] ONE    = CLK_DIV_W'(1);

    rx_state_e             state_q, state_d;
    logic [CLK_DIV_W-1:0]  cnt_q, div_q;
    logic [3:0]            nbits_q, bit_cnt_q;
    logic [1:0]            par_q;
    logic                  two_stop_q;
    logic [DATA_W-1:0]     shift_q;
    logic                  pbit_q, stop_err_q, stop1_low_q, samp_q;
    rx_status_t            status_q, status_c;

    logic rxs, bit_v;

    rx_bit_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rx_i   (uart_rx_i),
        .rxs_o  (rxs),
        .bit_o  (bit_v)
    );

    logic [3:0]        ds_eff;
    logic              active, start_det, last_data, last_stop, par_en, done, stop1_low;
    logic [DATA_W-1:0] data_w;

    assign ds_eff    = (cr_ds_i >= MIN_DS && cr_ds_i <= DW) ? cr_ds_i : DW;
    assign active    = (state_q == ST_START) || (state_q == ST_DATA) ||
                       (state_q == ST_PARITY) || (state_q == ST_STOP);
    assign start_det = (state_q == ST_IDLE) && !rxs;
    assign last_data = bit_cnt_q == (nbits_q - 4'd1);
    assign last_stop = bit_cnt_q == {3'b000, two_stop_q};
    assign par_en    = par_enabled(par_q);

    // samp_q marks the decision cycle, one cycle after each sample point
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE:      if (!rxs) state_d = ST_START;
            ST_START:     if (samp_q) state_d = bit_v ? ST_IDLE : ST_DATA;
            ST_DATA:      if (samp_q && last_data) state_d = par_en ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (samp_q) state_d = ST_STOP;
            ST_STOP: begin
                if (samp_q && last_stop) begin
                    done    = 1'b1;
                    state_d = rxs ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: if (rxs) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Word and status as seen at completion, folding in the final stop bit
    always_comb begin
        data_w              = shift_q >> (DW - nbits_q);
        stop1_low           = (bit_cnt_q == 4'd0) ? !bit_v : stop1_low_q;
        status_c.parity_err = par_en && ((^data_w ^ pbit_q) != (par_q == PAR_ODD));
        status_c.frame_err  = stop_err_q || !bit_v;
        status_c.brk        = (data_w == '0) && !(par_en && pbit_q) && stop1_low;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            div_q       <= '0;
            nbits_q     <= '0;
            par_q       <= PAR_NONE;
            two_stop_q  <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            pbit_q      <= 1'b0;
            stop_err_q  <= 1'b0;
            stop1_low_q <= 1'b0;
            samp_q      <= 1'b0;
        end else begin
            samp_q <= active && (cnt_q == '0);
            if (start_det) begin
                div_q       <= cr_clk_div_i;
                cnt_q       <= (cr_clk_div_i >> 1) - ONE;
                nbits_q     <= ds_eff;
                par_q       <= cr_p_i;
                two_stop_q  <= cr_s_i;
                bit_cnt_q   <= '0;
                shift_q     <= '0;
                pbit_q      <= 1'b0;
                stop_err_q  <= 1'b0;
                stop1_low_q <= 1'b0;
            end else if (active) begin
                cnt_q <= (cnt_q == '0) ? div_q - ONE : cnt_q - ONE;
            end
            if (samp_q) begin
                case (state_q)
                    ST_DATA: begin
                        shift_q   <= {bit_v, shift_q[DATA_W-1:1]};
                        bit_cnt_q <= last_data ? 4'd0 : bit_cnt_q + 4'd1;
                    end
                    ST_PARITY: pbit_q <= bit_v;
                    ST_STOP: begin
                        if (bit_cnt_q == 4'd0) stop1_low_q <= !bit_v;
                        stop_err_q <= stop_err_q | !bit_v;
                        bit_cnt_q  <= bit_cnt_q + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A completion while an unread word is held is dropped and flagged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o    <= '0;
            status_q  <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else if (done) begin
            if (!valid_o || ready_i) begin
                data_o    <= data_w;
                status_q  <= status_c;
                valid_o   <= 1'b1;
                overrun_o <= 1'b0;
            end else begin
                overrun_o <= 1'b1;
            end
        end else if (valid_o && ready_i) begin
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end
    end

    assign parity_err_o = status_q.parity_err;
    assign frame_err_o  = status_q.frame_err;
    assign break_o      = status_q.brk;

endmodule

// File: doc/rx_deframer.md
RX_DEFRAMER -- requirements
Module: rx_deframer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, maximum data bits per frame; legal 5..9.
REQ-002 SHALL have parameter CLK_DIV_W, default 16, width of the baud divider.
REQ-003 SHALL have parameter SYNC_STAGES, default 3, input synchronizer depth; legal >=2.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 cr_clk_div_i  in  CLK_DIV_W  clocks per bit; legal >=4.
REQ-007 cr_ds_i  in  4  data bits per frame; 5..DATA_W; any other value means DATA_W.
REQ-008 cr_p_i  in  2  parity mode: 00 none, 01 odd, 10 even, 11 even.
REQ-009 cr_s_i  in  1  stop bits: 0 one, 1 two.
REQ-010 uart_rx_i  in  1  serial line, asynchronous, idle high.
REQ-011 data_o  out  DATA_W  received data, right-aligned, unused upper bits 0.
REQ-012 parity_err_o / frame_err_o / break_o  out  1 each  status of held word.
REQ-013 overrun_o  out  1  a frame was dropped while the word was held.
REQ-014 valid_o  out  1 / ready_i  in  1  output handshake; transfer when both high.

Function
REQ-015 SHALL pass uart_rx_i through a SYNC_STAGES flop chain; all logic uses the last stage (rxs).
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-017 IDLE->START when rxs=0; cr_* values latched this cycle and used for the whole frame.
REQ-018 START: wait floor(div/2) cycles to mid-bit; rxs=1 there -> IDLE with no output (false start); else -> DATA.
REQ-019 Each later bit SHALL be sampled exactly div cycles after the previous sample point (baud counter reloaded with div-1).
REQ-020 DATA: shift in latched data-bit count, LSB first; -> PARITY if parity enabled, else -> STOP.
REQ-021 PARITY: parity_err = (XOR of data and parity bit) != (1 for odd, 0 for even); 0 when parity disabled.
REQ-022 STOP: sample 1 or 2 stop bits; any stop bit 0 -> frame_err=1.
REQ-023 break = all data bits 0, parity bit 0 if present, first stop bit 0; break implies frame_err.
REQ-024 After the last stop sample: -> IDLE if rxs=1, else -> WAIT_HIGH, leaving only when rxs=1 (no retrigger on held-low line).
REQ-025 Frame completes one cycle after the last stop sample point; valid_o rises the next cycle.
REQ-026 On completion with valid_o=0, or valid_o=1 and ready_i=1 in the same cycle: load data_o and flags, valid_o=1.
REQ-027 On completion with valid_o=1 and ready_i=0: frame dropped, held word unchanged, overrun_o=1.
REQ-028 Handshake without a simultaneous completion: valid_o=0, overrun_o=0; data_o and flags keep last value.

Reset
REQ-029 rst_ni=0 SHALL immediately set state IDLE, counters 0, synchronizer flops 1, all outputs 0.
REQ-030 Reset mid-frame SHALL abort the frame; no valid_o for it after release.

Configuration
REQ-031 RX_MAJORITY_VOTE_EN defined: each bit value = majority of rxs at sample point -1, 0, +1 cycle.
REQ-032 RX_MAJORITY_VOTE_EN undefined: bit value = rxs at sample point; decision in both modes at sample point +1 cycle, so latency is identical.

Structure
REQ-033 State enum, parity-mode encodings and frame-length constants SHALL live in package uart_pkg.
REQ-034 Synchronizer plus majority voter SHALL be sub-module rx_bit_sampler; counters, FSM and output register in rx_deframer.

Verification
REQ-035 div=16, 8N1, byte 0xA5, ready_i=1 -> data_o=0x0A5, all flags 0, valid_o high one cycle.
REQ-036 div=16, 7E2, data 0x41, parity bit 1 -> data_o=0x041, parity_err_o=1, frame_err_o=0.
REQ-037 Line low 3 cycles at div=16 -> no valid_o, FSM back in IDLE within 9 cycles.
REQ-038 Line low 12 bit times, 8N1 -> one valid_o, data_o=0, break_o=1, frame_err_o=1; no further frame until line high.
REQ-039 ready_i=0, frames 0x11 then 0x22 -> data_o=0x011, overrun_o=1; ready_i=1 -> valid_o=0, overrun_o=0.
REQ-040 1-cycle high glitch on a 0 data bit at the sample point -> bit read 0 with RX_MAJORITY_VOTE_EN, 1 without.
